// File: rtl/gol_sequencer.sv
// Conway's Game of Life sequencer on a toroidal NUM_ROWS x NUM_COLS board.
// One cell per cycle is swept into a scratch board, then committed atomically.
module gol_sequencer #(
  parameter  int unsigned NUM_ROWS = 8,
  parameter  int unsigned NUM_COLS = 8,
  localparam int unsigned N        = NUM_ROWS * NUM_COLS,
  localparam int unsigned AW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_req,
  input  logic          run_en,
  input  logic [15:0]   period,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic          load_val,
  input  logic          clear,
  output logic [N-1:0]  board,
  output logic          busy,
  output logic          gen_done,
  output logic [15:0]   gen_count
);

  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SWEEP  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  front_q, front_d;
  logic [N-1:0]  back_q, back_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   gen_count_q, gen_count_d;
  logic          gen_done_q, gen_done_d;
  logic          busy_q, busy_d;

  logic [RW-1:0] row_m, row_p;
  logic [CW-1:0] col_m, col_p;
  logic [3:0]    nbr_cnt;
  logic          cur_alive;
  logic          next_cell;
  logic [15:0]   period_eff;
  logic          timer_exp;

  function automatic logic cell_at(input logic [N-1:0] b,
                                   input logic [RW-1:0] r,
                                   input logic [CW-1:0] c);
    logic [AW-1:0] a;
    a = AW'(r) * AW'(NUM_COLS) + AW'(c);
    return b[a];
  endfunction

  // Toroidal neighbour coordinates and B3/S23 rule for the cell under the sweep
  always_comb begin
    row_m = (row_q == '0) ? RW'(NUM_ROWS - 1) : row_q - RW'(1);
    row_p = (row_q == RW'(NUM_ROWS - 1)) ? '0 : row_q + RW'(1);
    col_m = (col_q == '0) ? CW'(NUM_COLS - 1) : col_q - CW'(1);
    col_p = (col_q == CW'(NUM_COLS - 1)) ? '0 : col_q + CW'(1);

    nbr_cnt = 4'(cell_at(front_q, row_m, col_m)) + 4'(cell_at(front_q, row_m, col_q))
            + 4'(cell_at(front_q, row_m, col_p)) + 4'(cell_at(front_q, row_q, col_m))
            + 4'(cell_at(front_q, row_q, col_p)) + 4'(cell_at(front_q, row_p, col_m))
            + 4'(cell_at(front_q, row_p, col_q)) + 4'(cell_at(front_q, row_p, col_p));
    cur_alive = cell_at(front_q, row_q, col_q);
    next_cell = (nbr_cnt == 4'd3) || (cur_alive && (nbr_cnt == 4'd2));
  end

  // Auto-run timer expiry; a zero period behaves as one
  always_comb begin
    period_eff = (period == 16'd0) ? 16'd1 : period;
    timer_exp  = run_en && (timer_q >= (period_eff - 16'd1));
  end

  // Next-state and register-update logic
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    back_d      = back_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    timer_d     = timer_q;
    gen_count_d = gen_count_q;
    gen_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = run_en ? timer_q + 16'd1 : 16'd0;
        if (clear) begin
          front_d     = '0;
          gen_count_d = 16'd0;
          timer_d     = 16'd0;
        end else if (load_en) begin
          if (32'(load_addr) < N) begin
            front_d[load_addr] = load_val;
          end
        end else if (step_req || timer_exp) begin
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          timer_d = 16'd0;
          state_d = S_SWEEP;
        end
      end

      S_SWEEP: begin
        timer_d        = 16'd0;
        back_d[idx_q]  = next_cell;
        if (idx_q == AW'(N - 1)) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + AW'(1);
          if (col_q == CW'(NUM_COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      S_COMMIT: begin
        timer_d     = 16'd0;
        front_d     = back_q;
        gen_count_d = gen_count_q + 16'd1;
        gen_done_d  = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        timer_d = 16'd0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      front_q     <= '0;
      back_q      <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      timer_q     <= 16'd0;
      gen_count_q <= 16'd0;
      gen_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      back_q      <= back_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      timer_q     <= timer_d;
      gen_count_q <= gen_count_d;
      gen_done_q  <= gen_done_d;
      busy_q      <= busy_d;
    end
  end

  assign board     = front_q;
  assign busy      = busy_q;
  assign gen_done  = gen_done_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_gol_sequencer.sv
// Directed self-checking bench for gol_sequencer on the default 8x8 board.
module tb_gol_sequencer;

  localparam int unsigned N  = 64;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          step_req;
  logic          run_en;
  logic [15:0]   period;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic          load_val;
  logic          clear;
  logic [N-1:0]  board;
  logic          busy;
  logic          gen_done;
  logic [15:0]   gen_count;

  int errors = 0;
  int checks = 0;

  gol_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .step_req  (step_req),
    .run_en    (run_en),
    .period    (period),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_val  (load_val),
    .clear     (clear),
    .board     (board),
    .busy      (busy),
    .gen_done  (gen_done),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] bits3(input int a, input int b, input int c);
    logic [N-1:0] m;
    m = '0;
    m[a] = 1'b1;
    m[b] = 1'b1;
    m[c] = 1'b1;
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; step_req = 1'b0; run_en = 1'b0; period = 16'd0;
    load_en = 1'b0; load_addr = '0; load_val = 1'b0; clear = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic load_cell(input int a, input logic v);
    load_en = 1'b1; load_addr = AW'(a); load_val = v;
    tick;
    load_en = 1'b0;
  endtask

  task automatic load_blinker;
    load_cell(26, 1'b1);
    load_cell(27, 1'b1);
    load_cell(28, 1'b1);
  endtask

  task automatic wait_done(input int max_n, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < max_n && !ok; i++) begin
      tick;
      n++;
      if (gen_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic step_and_wait(output int n, output bit ok);
    step_req = 1'b1;
    tick;
    step_req = 1'b0;
    wait_done(100, n, ok);
  endtask

  task automatic count_pulses(input int cycles, output int p);
    p = 0;
    for (int i = 0; i < cycles; i++) begin
      tick;
      if (gen_done === 1'b1) p++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (board !== 64'h0) begin errors++; $display("FAIL reset_board: got %h exp %h", board, 64'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL reset_gen_done: got %b exp 0", gen_done); end
    checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL reset_gen_count: got %0d exp 0", gen_count); end
  endtask

  task automatic test_load;
    int p;
    do_reset;
    load_cell(5, 1'b1);
    load_cell(63, 1'b1);
    load_cell(5, 1'b0);
    checks++; if (board !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL load_bits: got %h exp %h", board, 64'h8000_0000_0000_0000); end
    load_en = 1'b1; load_addr = AW'(10); load_val = 1'b1; step_req = 1'b1;
    tick;
    load_en = 1'b0; step_req = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_over_step_busy: got %b exp 0", busy); end
    checks++; if (board !== 64'h8000_0000_0000_0400) begin errors++; $display("FAIL load_over_step_board: got %h exp %h", board, 64'h8000_0000_0000_0400); end
    count_pulses(70, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL load_no_gen: got %0d pulses exp 0", p); end
  endtask

  task automatic test_blinker;
    int n;
    bit ok;
    int p;
    do_reset;
    load_blinker;
    checks++; if (board !== bits3(26, 27, 28)) begin errors++; $display("FAIL blinker_loaded: got %h exp %h", board, bits3(26, 27, 28)); end
    step_req = 1'b1;
    tick;
    step_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL blinker_busy_rise: got %b exp 1", busy); end
    repeat (10) tick;
    checks++; if (board !== bits3(26, 27, 28)) begin errors++; $display("FAIL blinker_front_stable: got %h exp %h", board, bits3(26, 27, 28)); end
    wait_done(100, n, ok);
    checks++; if (!ok || n != 55) begin errors++; $display("FAIL blinker_latency: got ok=%0d n=%0d exp ok=1 n=55", ok, n); end
    checks++; if (board !== bits3(19, 27, 35)) begin errors++; $display("FAIL blinker_board: got %h exp %h", board, bits3(19, 27, 35)); end
    checks++; if (gen_count !== 16'd1) begin errors++; $display("FAIL blinker_gen_count: got %0d exp 1", gen_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blinker_busy_fall: got %b exp 0", busy); end
    tick;
    checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL blinker_done_pulse: got %b exp 0", gen_done); end
    count_pulses(20, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL blinker_extra_pulses: got %0d exp 0", p); end
  endtask

  task automatic test_wrap;
    int n;
    bit ok;
    do_reset;
    load_cell(7, 1'b1);
    load_cell(0, 1'b1);
    load_cell(1, 1'b1);
    step_and_wait(n, ok);
    checks++; if (!ok || n != 65) begin errors++; $display("FAIL wrap_latency1: got ok=%0d n=%0d exp ok=1 n=65", ok, n); end
    checks++; if (board !== bits3(56, 0, 8)) begin errors++; $display("FAIL wrap_board1: got %h exp %h", board, bits3(56, 0, 8)); end
    step_and_wait(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout2: got ok=%0d exp 1", ok); end
    checks++; if (board !== bits3(7, 0, 1)) begin errors++; $display("FAIL wrap_board2: got %h exp %h", board, bits3(7, 0, 1)); end
    checks++; if (gen_count !== 16'd2) begin errors++; $display("FAIL wrap_gen_count: got %0d exp 2", gen_count); end
  endtask

  task automatic test_still_life;
    int n;
    bit ok;
    logic [N-1:0] blk;
    do_reset;
    load_cell(0, 1'b1);
    load_cell(1, 1'b1);
    load_cell(8, 1'b1);
    load_cell(9, 1'b1);
    blk = 64'h0000_0000_0000_0303;
    period = 16'd10;
    run_en = 1'b1;
    wait_done(200, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL still_first_timeout: got ok=%0d exp 1", ok); end
    checks++; if (board !== blk) begin errors++; $display("FAIL still_board0: got %h exp %h", board, blk); end
    for (int k = 1; k < 5; k++) begin
      wait_done(200, n, ok);
      checks++; if (!ok || n != 75) begin errors++; $display("FAIL still_spacing%0d: got ok=%0d n=%0d exp ok=1 n=75", k, ok, n); end
      checks++; if (board !== blk) begin errors++; $display("FAIL still_board%0d: got %h exp %h", k, board, blk); end
    end
    run_en = 1'b0;
    checks++; if (gen_count !== 16'd5) begin errors++; $display("FAIL still_gen_count: got %0d exp 5", gen_count); end
    repeat (3) tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL still_stopped: got busy=%b exp 0", busy); end
  endtask

  task automatic test_busy_drop;
    int n;
    bit ok;
    int p;
    do_reset;
    load_blinker;
    step_req = 1'b1;
    tick;
    step_req = 1'b0;
    repeat (20) tick;
    step_req = 1'b1; load_en = 1'b1; load_addr = AW'(0); load_val = 1'b1; clear = 1'b1;
    tick;
    step_req = 1'b0; load_en = 1'b0; clear = 1'b0;
    wait_done(100, n, ok);
    checks++; if (!ok || n != 44) begin errors++; $display("FAIL drop_latency: got ok=%0d n=%0d exp ok=1 n=44", ok, n); end
    checks++; if (board !== bits3(19, 27, 35)) begin errors++; $display("FAIL drop_board: got %h exp %h", board, bits3(19, 27, 35)); end
    count_pulses(80, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL drop_extra_gen: got %0d pulses exp 0", p); end
    checks++; if (gen_count !== 16'd1) begin errors++; $display("FAIL drop_gen_count: got %0d exp 1", gen_count); end
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    int p;
    do_reset;
    load_blinker;
    step_and_wait(n, ok);
    checks++; if (gen_count !== 16'd1) begin errors++; $display("FAIL rstmid_pre_count: got %0d exp 1", gen_count); end
    step_req = 1'b1;
    tick;
    step_req = 1'b0;
    repeat (30) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (board !== 64'h0) begin errors++; $display("FAIL rstmid_board: got %h exp %h", board, 64'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL rstmid_gen_count: got %0d exp 0", gen_count); end
    count_pulses(80, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL rstmid_gen_done: got %0d pulses exp 0", p); end
  endtask

  task automatic test_priority;
    int n;
    bit ok;
    int p;
    do_reset;
    load_blinker;
    step_and_wait(n, ok);
    clear = 1'b1; step_req = 1'b1;
    tick;
    clear = 1'b0; step_req = 1'b0;
    checks++; if (board !== 64'h0) begin errors++; $display("FAIL prio_board: got %h exp %h", board, 64'h0); end
    checks++; if (gen_count !== 16'd0) begin errors++; $display("FAIL prio_gen_count: got %0d exp 0", gen_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b exp 0", busy); end
    count_pulses(70, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL prio_gen_done: got %0d pulses exp 0", p); end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    int p;
    do_reset;
    load_blinker;
    period = 16'd0;
    run_en = 1'b1;
    wait_done(200, n, ok);
    checks++; if (!ok || n != 66) begin errors++; $display("FAIL b2b_first: got ok=%0d n=%0d exp ok=1 n=66", ok, n); end
    checks++; if (board !== bits3(19, 27, 35)) begin errors++; $display("FAIL b2b_board1: got %h exp %h", board, bits3(19, 27, 35)); end
    wait_done(200, n, ok);
    run_en = 1'b0;
    checks++; if (!ok || n != 66) begin errors++; $display("FAIL b2b_spacing: got ok=%0d n=%0d exp ok=1 n=66", ok, n); end
    checks++; if (board !== bits3(26, 27, 28)) begin errors++; $display("FAIL b2b_board2: got %h exp %h", board, bits3(26, 27, 28)); end
    checks++; if (gen_count !== 16'd2) begin errors++; $display("FAIL b2b_gen_count: got %0d exp 2", gen_count); end
    tick;
    // step_req coinciding with timer expiry
    run_en = 1'b1; step_req = 1'b1;
    tick;
    run_en = 1'b0; step_req = 1'b0;
    wait_done(100, n, ok);
    checks++; if (!ok || n != 65) begin errors++; $display("FAIL coinc_latency: got ok=%0d n=%0d exp ok=1 n=65", ok, n); end
    checks++; if (gen_count !== 16'd3) begin errors++; $display("FAIL coinc_gen_count: got %0d exp 3", gen_count); end
    checks++; if (board !== bits3(19, 27, 35)) begin errors++; $display("FAIL coinc_board: got %h exp %h", board, bits3(19, 27, 35)); end
    count_pulses(70, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL coinc_extra_gen: got %0d pulses exp 0", p); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_load;
    test_blinker;
    test_wrap;
    test_still_life;
    test_busy_drop;
    test_reset_mid;
    test_priority;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
